// File: rtl/turf_event_ctrl_initiator.sv
// Host-side initiator for the TURF event control UDP protocol: sends one
// single-beat command packet, waits for the matching reply with timeout and retries.
module turf_event_ctrl_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned MAX_RETRIES    = 2,
  parameter int unsigned CNT_BITS       = 24
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_code,
  input  logic [47:0] cmd_arg,
  input  logic [31:0] target_ip,
  input  logic [15:0] target_port,
  output logic        resp_valid,
  output logic [63:0] resp_data,
  output logic [1:0]  resp_status,
  output logic [63:0] m_udphdr_tdata,
  output logic        m_udphdr_tvalid,
  input  logic        m_udphdr_tready,
  output logic [63:0] m_udpdata_tdata,
  output logic [7:0]  m_udpdata_tkeep,
  output logic        m_udpdata_tlast,
  output logic        m_udpdata_tvalid,
  input  logic        m_udpdata_tready,
  input  logic [63:0] s_udphdr_tdata,
  input  logic        s_udphdr_tvalid,
  output logic        s_udphdr_tready,
  input  logic [63:0] s_udpdata_tdata,
  input  logic [7:0]  s_udpdata_tkeep,
  input  logic        s_udpdata_tlast,
  input  logic        s_udpdata_tvalid,
  output logic        s_udpdata_tready
);

  localparam int unsigned RETRY_BITS = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_BADRESP = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;

  typedef enum logic [3:0] {
    IDLE,
    SEND_HDR,
    SEND_DATA,
    WAIT_HDR,
    SKIP,
    READ_RESP,
    FLUSH_RESP,
    FLUSH,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic [RETRY_BITS-1:0] retry_q, retry_d;
  logic [15:0]           code_q, code_d;
  logic [47:0]           arg_q, arg_d;
  logic [31:0]           ip_q, ip_d;
  logic [15:0]           port_q, port_d;
  logic [63:0]           resp_data_d;
  logic [1:0]            resp_status_d;
  logic                  hdr_rdy_q;

  logic cmd_fire;
  logic hdr_fire;
  logic data_fire;
  logic hdr_match;
  logic expired;
  logic unused_len;

  // Command accept outranks a stray header, so header ready drops while a command lands
  assign cmd_fire        = cmd_valid & cmd_ready;
  assign s_udphdr_tready = hdr_rdy_q & ~areset & ~cmd_fire;
  assign hdr_fire        = s_udphdr_tvalid & s_udphdr_tready;
  assign data_fire       = s_udpdata_tvalid & s_udpdata_tready;
  assign hdr_match       = (s_udphdr_tdata[63:32] == ip_q) && (s_udphdr_tdata[31:16] == port_q);
  assign expired         = (cnt_q == CNT_LAST);
  assign unused_len      = ^s_udphdr_tdata[15:0];

  assign m_udphdr_tdata  = {ip_q, port_q, 16'd8};
  assign m_udpdata_tdata = {arg_q, code_q};
  assign m_udpdata_tkeep = 8'hFF;
  assign m_udpdata_tlast = 1'b1;

  // Next-state and datapath update
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    retry_d       = retry_q;
    code_d        = code_q;
    arg_d         = arg_q;
    ip_d          = ip_q;
    port_d        = port_q;
    resp_data_d   = resp_data;
    resp_status_d = resp_status;

    unique case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          code_d  = cmd_code;
          arg_d   = cmd_arg;
          ip_d    = target_ip;
          port_d  = target_port;
          retry_d = '0;
          state_d = SEND_HDR;
        end else if (hdr_fire) begin
          state_d = FLUSH;
        end
      end
      SEND_HDR: begin
        if (m_udphdr_tvalid && m_udphdr_tready) state_d = SEND_DATA;
      end
      SEND_DATA: begin
        if (m_udpdata_tvalid && m_udpdata_tready) begin
          cnt_d   = '0;
          state_d = WAIT_HDR;
        end
      end
      WAIT_HDR: begin
        if (hdr_fire) begin
          if (!expired) cnt_d = cnt_q + CNT_BITS'(1);
          state_d = hdr_match ? READ_RESP : SKIP;
        end else if (expired) begin
          if (32'(retry_q) < MAX_RETRIES) begin
            retry_d = retry_q + RETRY_BITS'(1);
            state_d = SEND_HDR;
          end else begin
            resp_status_d = ST_TIMEOUT;
            state_d       = DONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_BITS'(1);
        end
      end
      SKIP: begin
        // Counter saturates so an expiry here is taken back in WAIT_HDR
        if (!expired) cnt_d = cnt_q + CNT_BITS'(1);
        if (data_fire && s_udpdata_tlast) state_d = WAIT_HDR;
      end
      READ_RESP: begin
        if (data_fire) begin
          if ((s_udpdata_tkeep == 8'hFF) && (s_udpdata_tdata[15:0] == code_q)) begin
            resp_data_d   = s_udpdata_tdata;
            resp_status_d = ST_OK;
          end else begin
            resp_status_d = ST_BADRESP;
          end
          state_d = s_udpdata_tlast ? DONE : FLUSH_RESP;
        end
      end
      FLUSH_RESP: begin
        if (data_fire && s_udpdata_tlast) state_d = DONE;
      end
      FLUSH: begin
        if (data_fire && s_udpdata_tlast) state_d = IDLE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      retry_q          <= '0;
      code_q           <= '0;
      arg_q            <= '0;
      ip_q             <= '0;
      port_q           <= '0;
      hdr_rdy_q        <= 1'b0;
      cmd_ready        <= 1'b1;
      m_udphdr_tvalid  <= 1'b0;
      m_udpdata_tvalid <= 1'b0;
      s_udpdata_tready <= 1'b0;
      resp_valid       <= 1'b0;
      resp_status      <= '0;
      resp_data        <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      retry_q          <= retry_d;
      code_q           <= code_d;
      arg_q            <= arg_d;
      ip_q             <= ip_d;
      port_q           <= port_d;
      hdr_rdy_q        <= (state_d == IDLE) || (state_d == WAIT_HDR);
      cmd_ready        <= (state_d == IDLE);
      m_udphdr_tvalid  <= (state_d == SEND_HDR);
      m_udpdata_tvalid <= (state_d == SEND_DATA);
      s_udpdata_tready <= (state_d == SKIP) || (state_d == READ_RESP) ||
                          (state_d == FLUSH_RESP) || (state_d == FLUSH);
      resp_valid       <= (state_d == DONE);
      resp_status      <= resp_status_d;
      resp_data        <= resp_data_d;
    end
  end

endmodule
